// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its program memory.
// Instruction layout: {opcode[7:4], dst[3:2], src[1:0]}.
package instr_sequencer_pkg;

   localparam int DEPTH_DEF   = 16;
   localparam int INSTR_W_DEF = 8;

   localparam int OP_MSB = 7;
   localparam int OP_LSB = 4;
   localparam int DST_MSB = 3;
   localparam int DST_LSB = 2;
   localparam int SRC_MSB = 1;
   localparam int SRC_LSB = 0;

   localparam logic [3:0] HALT_OP = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } seq_state_e;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x INSTR_W, one write port, registered read (data one cycle after rd_en).
// No reset; contents survive sequencer reset. No backpressure.
module prog_mem
   import instr_sequencer_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [INSTR_W-1:0]         wr_data,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [INSTR_W-1:0]         rd_data
);

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [INSTR_W-1:0] rd_data_d;
   logic [INSTR_W-1:0] rd_data_q;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_sequencer.sv
// Loads a program into prog_mem, then issues it one instruction per valid/ready transfer.
// Fetch+issue takes 2 cycles per instruction; instr holds stable while instr_ready is low.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en,
   input  logic                       load_strobe,
   input  logic [INSTR_W-1:0]         load_data,
   input  logic                       run,
   input  logic                       step,
   output logic [INSTR_W-1:0]         instr,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [$clog2(DEPTH)-1:0]   pc,
   output logic [$clog2(DEPTH):0]     prog_len,
   output logic                       halted
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

   seq_state_e           state_d, state_q;
   logic [AW-1:0]        pc_d, pc_q;
   logic [AW:0]          len_d, len_q;
   logic [AW:0]          pc_inc;
   logic                 wr_en;
   logic                 rd_en;
   logic                 last;
   logic [INSTR_W-1:0]   rd_data;

   prog_mem #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (len_q[AW-1:0]),
      .wr_data (load_data),
      .rd_en   (rd_en),
      .rd_addr (pc_q),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      pc_inc  = {1'b0, pc_q} + LEN_ONE;
      // HALT_OP ends the program even when more instructions are loaded behind it
      last    = (rd_data[OP_MSB:OP_LSB] == HALT_OP) || (pc_inc == len_q);

      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (load_en) begin
               state_d = S_LOAD;
               len_d   = '0;
               pc_d    = '0;
            end else if (state_q == S_IDLE && (run || step)) begin
               state_d = (len_q == '0) ? S_HALT : S_FETCH;
            end
         end
         S_LOAD: begin
            if (!load_en) begin
               state_d = S_IDLE;
            end
            if (load_strobe && len_q != LEN_FULL) begin
               wr_en = 1'b1;
               len_d = len_q + LEN_ONE;
            end
         end
         S_FETCH: begin
            rd_en   = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (instr_ready) begin
               pc_d = pc_inc[AW-1:0];
               if (last) begin
                  state_d = S_HALT;
               end else if (run) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
      end
   end

   assign instr_valid = (state_q == S_ISSUE);
   assign instr       = instr_valid ? rd_data : '0;
   assign halted      = (state_q == S_HALT);
   assign pc          = pc_q;
   assign prog_len    = len_q;

endmodule
